ni_flit_rx: RTL and testbench

Receive-side flit assembler between the NoC link and the NI request FSM. Captures the head, body and tail flits of each request packet from the 16-bit NoC input. Assembles them into a `req_packet_s` and holds up to two complete packets in a ping-pong buffer, so the NoC can stream back-to-back packets while the APB bridge drains them. Partial packets abandoned by the NoC are dropped after a gap timeout.

---
 rtl/fsm_pkg.sv | 9 +
 rtl/ni_pkg.sv | 13 +
 rtl/ni_pkt_buf.sv | 57 +++++
 rtl/ni_flit_rx.sv | 104 ++++++++++
 tb/tb_ni_flit_rx.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_pkg.sv
// State encodings for the NI receive path.
package fsm_pkg;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_e;

endpackage

// File: rtl/ni_pkg.sv
// Shared NI definitions: flit geometry and the assembled request packet.
package ni_pkg;

    localparam int FLIT_W      = 16;
    localparam int TOTAL_FLITS = 4;

    typedef struct packed {
        logic [FLIT_W-1:0]                    head_flit;
        logic [TOTAL_FLITS-3:0][FLIT_W-1:0]   body_flit;
        logic [FLIT_W-1:0]                    tail_flit;
    } req_packet_s;

endpackage

// File: rtl/ni_pkt_buf.sv
// Two-entry ping-pong packet store; the slot being filled is never the slot being read.
module ni_pkt_buf
    import ni_pkg::*;
#(
    parameter int NFLITS = ni_pkg::TOTAL_FLITS,
    parameter int IDX_W  = $clog2(NFLITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_slot,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [FLIT_W-1:0]    wr_flit,
    input  logic                 commit,
    input  logic                 release_en,
    input  logic                 pop,
    output logic [1:0]           count,
    output req_packet_s          pkt,
    output logic                 pkt_valid
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NFLITS - 1);

    req_packet_s slot [2];
    logic        rd_ptr;

    // Slot data needs no reset: it is only visible once count says it is committed.
    always_ff @(posedge clk) begin
        if (release_en) begin
            slot[wr_slot] <= '0;
        end else if (wr_en) begin
            if (wr_idx == '0) begin
                slot[wr_slot].head_flit <= wr_flit;
            end else if (wr_idx == IDX_LAST) begin
                slot[wr_slot].tail_flit <= wr_flit;
            end else begin
                slot[wr_slot].body_flit[wr_idx - 1'b1] <= wr_flit;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
        end else begin
            count <= count + {1'b0, commit} - {1'b0, pop};
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign pkt_valid = (count != 2'd0);
    assign pkt       = slot[rd_ptr];

endmodule

// File: rtl/ni_flit_rx.sv
// Receive-side flit assembler: frames NoC flits into request packets and buffers two of them.
module ni_flit_rx
    import ni_pkg::*;
    import fsm_pkg::*;
#(
    parameter int FLIT_W      = ni_pkg::FLIT_W,
    parameter int NFLITS      = ni_pkg::TOTAL_FLITS,
    parameter int GAP_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLIT_W-1:0]  i_flit,
    input  logic               enable,
    output logic               rx_ready,
    output req_packet_s        pkt,
    output logic               pkt_valid,
    input  logic               pkt_ready,
    output logic               err_drop,
    output rx_state_e          dbg_state
);

    localparam int IDX_W = (NFLITS > 1) ? $clog2(NFLITS) : 1;
    localparam int GAP_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NFLITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

    rx_state_e          state;
    logic [IDX_W-1:0]   idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic               wr_ptr;
    logic [1:0]         count;
    logic               accept;
    logic               commit;
    logic               drop;
    logic               pop;

    // Mid-packet the slot is already reserved, so readiness depends only on registers.
    assign rx_ready = (state == RX_RECV) || (count < 2'd2);
    assign accept   = enable && rx_ready;
    assign commit   = accept && (state == RX_RECV) && (idx == IDX_LAST);
    assign drop     = (state == RX_RECV) && !accept && (gap_cnt == GAP_LAST);
    assign pop      = pkt_valid && pkt_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RX_IDLE;
            idx      <= '0;
            gap_cnt  <= '0;
            wr_ptr   <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            err_drop <= drop;
            case (state)
                RX_IDLE: begin
                    gap_cnt <= '0;
                    if (accept) begin
                        idx   <= IDX_W'(1);
                        state <= RX_RECV;
                    end
                end
                RX_RECV: begin
                    if (accept) begin
                        gap_cnt <= '0;
                        if (idx == IDX_LAST) begin
                            idx    <= '0;
                            wr_ptr <= ~wr_ptr;
                            state  <= RX_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        idx     <= '0;
                        state   <= RX_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

    ni_pkt_buf #(
        .NFLITS (NFLITS),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .wr_slot    (wr_ptr),
        .wr_en      (accept),
        .wr_idx     (idx),
        .wr_flit    (i_flit),
        .commit     (commit),
        .release_en (drop),
        .pop        (pop),
        .count      (count),
        .pkt        (pkt),
        .pkt_valid  (pkt_valid)
    );

endmodule

// File: tb/tb_ni_flit_rx.sv
// Directed bench for ni_flit_rx with NFLITS = 4 and GAP_TIMEOUT = 4.
module tb_ni_flit_rx;
    import ni_pkg::*;
    import fsm_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] i_flit;
    logic        enable;
    logic        rx_ready;
    req_packet_s pkt;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        err_drop;
    rx_state_e   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    ni_flit_rx #(
        .FLIT_W      (16),
        .NFLITS      (4),
        .GAP_TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_flit    (i_flit),
        .enable    (enable),
        .rx_ready  (rx_ready),
        .pkt       (pkt),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .err_drop  (err_drop),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_pkt(input logic [15:0] h, input logic [15:0] b0,
                                            input logic [15:0] b1, input logic [15:0] t);
        req_packet_s p;
        p.head_flit    = h;
        p.body_flit[0] = b0;
        p.body_flit[1] = b1;
        p.tail_flit    = t;
        return p;
    endfunction

    // drivers
    task automatic send_flit(input logic [15:0] f);
        int waited = 0;
        i_flit = f;
        enable = 1'b1;
        while (!rx_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("rx_ready_wait", rx_ready, 1);
        tick();
    endtask

    task automatic send_pkt(input logic [15:0] h, input logic [15:0] b0,
                            input logic [15:0] b1, input logic [15:0] t);
        send_flit(h);
        send_flit(b0);
        send_flit(b1);
        send_flit(t);
        enable = 1'b0;
        exp_q.push_back(mk_pkt(h, b0, b1, t));
    endtask

    task automatic pop_one(input string tag);
        logic [63:0] exp;
        exp = exp_q.pop_front();
        check({tag, "_valid"}, pkt_valid, 1);
        check({tag, "_pkt"}, pkt, exp);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        i_flit    = '0;
        pkt_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_rx_ready", rx_ready, 1);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_err_drop", err_drop, 0);
        check("rst_state", dbg_state, RX_IDLE);

        // single packet, downstream always ready
        pkt_ready = 1'b1;
        send_flit(16'h1111);
        send_flit(16'h2222);
        send_flit(16'h3333);
        check("single_not_yet_valid", pkt_valid, 0);
        send_flit(16'h4444);
        enable = 1'b0;
        check("single_valid", pkt_valid, 1);
        check("single_pkt", pkt, 64'h1111_3333_2222_4444);
        tick();
        check("single_valid_one_cycle", pkt_valid, 0);
        pkt_ready = 1'b0;

        // backpressure: A and B buffered, C head stalls
        send_pkt(16'hA000, 16'hA001, 16'hA002, 16'hA003);
        send_pkt(16'hB000, 16'hB001, 16'hB002, 16'hB003);
        exp_q.push_back(mk_pkt(16'hC000, 16'hC001, 16'hC002, 16'hC003));
        i_flit = 16'hC000;
        enable = 1'b1;
        check("bp_full_not_ready", rx_ready, 0);
        check("bp_head_A", pkt, mk_pkt(16'hA000, 16'hA001, 16'hA002, 16'hA003));
        tick();
        check("bp_still_not_ready", rx_ready, 0);
        check("bp_A_stable", pkt, exp_q[0]);
        check("bp_state_idle", dbg_state, RX_IDLE);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        void'(exp_q.pop_front());
        check("bp_ready_after_pop", rx_ready, 1);
        check("bp_state_still_idle", dbg_state, RX_IDLE);
        check("bp_head_B", pkt, mk_pkt(16'hB000, 16'hB001, 16'hB002, 16'hB003));
        tick();
        check("bp_C_head_taken", dbg_state, RX_RECV);
        send_flit(16'hC001);
        send_flit(16'hC002);
        send_flit(16'hC003);
        enable = 1'b0;
        pop_one("bp_B");
        pop_one("bp_C");
        check("bp_drained", pkt_valid, 0);

        // tail commit coincides with a pop
        send_pkt(16'hD000, 16'hD001, 16'hD002, 16'hD003);
        send_flit(16'hE000);
        send_flit(16'hE001);
        send_flit(16'hE002);
        check("sim_head_D", pkt, exp_q[0]);
        i_flit    = 16'hE003;
        enable    = 1'b1;
        pkt_ready = 1'b1;
        tick();
        enable    = 1'b0;
        pkt_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(mk_pkt(16'hE000, 16'hE001, 16'hE002, 16'hE003));
        check("sim_count", dut.u_buf.count, 1);
        pop_one("sim_E");
        check("sim_drained", pkt_valid, 0);

        // gap of four idle cycles drops the partial packet
        send_flit(16'h5000);
        send_flit(16'h5001);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_no_drop_yet", err_drop, 0);
            check("gap_still_recv", dbg_state, RX_RECV);
        end
        tick();
        check("gap_drop_pulse", err_drop, 1);
        check("gap_back_idle", dbg_state, RX_IDLE);
        check("gap_no_valid", pkt_valid, 0);
        tick();
        check("gap_drop_single", err_drop, 0);
        check("gap_still_no_valid", pkt_valid, 0);
        send_pkt(16'h6000, 16'h6001, 16'h6002, 16'h6003);
        pop_one("gap_after");

        // gap of three idle cycles is tolerated
        send_flit(16'h7000);
        send_flit(16'h7001);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("short_gap_no_drop", err_drop, 0);
        end
        send_flit(16'h7002);
        send_flit(16'h7003);
        enable = 1'b0;
        exp_q.push_back(64'h7000_7002_7001_7003);
        check("short_gap_no_drop_end", err_drop, 0);
        pop_one("short_gap");

        // reset in the middle of a packet
        send_flit(16'h8000);
        send_flit(16'h8001);
        enable = 1'b0;
        reset  = 1'b1;
        #1;
        check("mid_rst_valid", pkt_valid, 0);
        check("mid_rst_ready", rx_ready, 1);
        check("mid_rst_drop", err_drop, 0);
        check("mid_rst_state", dbg_state, RX_IDLE);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_drop", err_drop, 0);
        send_pkt(16'h9000, 16'h9001, 16'h9002, 16'h9003);
        check("post_rst_drop_after_pkt", err_drop, 0);
        pop_one("post_rst");
        check("final_empty", pkt_valid, 0);
        check("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
